// File: rtl/uart_pkg.sv
// Shared UART definitions for the rx stage and the future tx stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART rx front end and the MMIO read path.
// Latency: n/a (wiring only).
// Backpressure: none; rx_ren pops one byte per cycle, a full FIFO drops bytes.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic                   rx;
  logic                   rx_ren;
  logic                   err_clr;
  logic [UART_DATA_W-1:0] uart_dout;
  logic                   rx_data_present;
  logic                   rx_full;
  logic                   frame_err;
  logic                   overrun;

  // master: the MMIO side (and the serial line) driving the receiver
  modport master (
    output rx, rx_ren, err_clr,
    input  uart_dout, rx_data_present, rx_full, frame_err, overrun
  );

  // slave: the receiver itself
  modport slave (
    input  rx, rx_ren, err_clr,
    output uart_dout, rx_data_present, rx_full, frame_err, overrun
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word (0 when empty).
// Latency: a push into an empty FIFO shows on dout the cycle after the push edge.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count;
  logic [W-1:0]  head;
  logic          do_push;
  logic          do_pop;

  // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
    rd_nxt  = rd_ptr + 1'b1;
  end

  // Storage array; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + CW'(do_push) - CW'(do_pop);
      if (do_pop) begin
        // With one entry left the next head is either the incoming byte or nothing.
        if (count == CW'(1)) head <= do_push ? din : '0;
        else                 head <= mem[rd_nxt];
      end else if (do_push && empty) begin
        head <= din;
      end
    end
  end

  assign dout = head;

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver feeding a small FWFT byte FIFO.
// Latency: byte visible on uart_dout the cycle after its stop-bit sample.
// Backpressure: none; bytes arriving while full are dropped and flag overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 27,
  parameter int DEPTH   = 8
) (
  input  logic           clk,
  input  logic           Rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int        PRE_W    = $clog2(CLK_DIV);
  localparam logic [3:0] SMP_MID  = 4'(UART_OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SMP_LAST = 4'(UART_OVERSAMPLE - 1);

  rx_state_t              state;
  logic                   rx_q1;
  logic                   rxs;
  logic [PRE_W-1:0]       presc;
  logic                   tick;
  logic [3:0]             smp;
  logic [2:0]             bitcnt;
  logic [UART_DATA_W-1:0] shreg;
  logic                   push;
  logic                   drop;
  logic                   empty;
  logic                   full;
  logic                   frame_err;
  logic                   overrun;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (Rst) begin
      rx_q1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_q1 <= bus.rx;
      rxs   <= rx_q1;
    end
  end

  assign tick = (presc == PRE_W'(CLK_DIV - 1));

  // Oversample prescaler, realigned to the falling edge that opens a frame.
  always_ff @(posedge clk) begin
    if (Rst)                        presc <= '0;
    else if (state == IDLE && !rxs) presc <= '0;
    else if (tick)                  presc <= '0;
    else                            presc <= presc + 1'b1;
  end

  // Push happens on the stop-bit sample itself so the byte appears one cycle later.
  assign push = (state == STOP) && tick && (smp == SMP_LAST) && rxs;

  // Receiver FSM with counters, shift register and the sticky framing flag.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= IDLE;
      smp       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      // Clear first so a framing error in the same cycle overrides it.
      if (bus.err_clr) frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            smp   <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (smp == SMP_MID) begin
              smp    <= '0;
              bitcnt <= '0;
              state  <= rxs ? IDLE : DATA;
            end else begin
              smp <= smp + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            smp <= smp + 1'b1;
            if (smp == SMP_LAST) begin
              shreg <= {rxs, shreg[UART_DATA_W-1:1]};
              if (bitcnt == 3'd7) state <= STOP;
              else                bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            smp <= smp + 1'b1;
            if (smp == SMP_LAST) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun; a drop in the clearing cycle still leaves it set.
  always_ff @(posedge clk) begin
    if (Rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (bus.err_clr) overrun <= 1'b0;
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (Rst),
    .push  (push),
    .din   (shreg),
    .pop   (bus.rx_ren),
    .dout  (bus.uart_dout),
    .empty (empty),
    .full  (full),
    .drop  (drop)
  );

  assign bus.rx_data_present = !empty;
  assign bus.rx_full         = full;
  assign bus.frame_err       = frame_err;
  assign bus.overrun         = overrun;

endmodule
